// File: rtl/param_sweep_engine_pkg.sv
// Shared definitions for the parameter sweep engine: command opcodes,
// the sweep FSM state encoding and the per-word saturate/wrap helper.
package param_sweep_engine_pkg;

   typedef enum logic {
      OP_ZERO   = 1'b0,
      OP_UPDATE = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ZERO,
      S_RD,
      S_DRAIN,
      S_DONE
   } state_e;

   // Read-to-write distance of the update pipe; DRAIN lasts this many cycles.
   localparam int PIPE_DEPTH = 2;

   // Clamp x to the signed range of a w-bit word when sat_en is set, else
   // return x unchanged so the caller's narrowing cast wraps it.
   function automatic logic signed [63:0] reduce_word(
      input logic signed [63:0] x,
      input int                 w,
      input logic               sat_en
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (sat_en && (x > hi)) return hi;
      if (sat_en && (x < lo)) return lo;
      return x;
   endfunction

endpackage

// File: rtl/param_sweep_lane.sv
// One lane of the momentum-SGD update: purely combinational.
//   v' = v - (v >>> MU_SHIFT) - (g >>> LR_SHIFT),  w' = w + v'
// Math runs two bits wider than a word. Define PARAM_SWEEP_SAT_EN to
// saturate v' and w' to the word range; otherwise they wrap.
import param_sweep_engine_pkg::*;

module param_sweep_lane #(
   parameter int WORD_WIDTH = 18,
   parameter int LR_SHIFT   = 7,
   parameter int MU_SHIFT   = 3
) (
   input  logic signed [WORD_WIDTH-1:0] w_i,
   input  logic signed [WORD_WIDTH-1:0] v_i,
   input  logic signed [WORD_WIDTH-1:0] g_i,
   output logic signed [WORD_WIDTH-1:0] w_o,
   output logic signed [WORD_WIDTH-1:0] v_o
);

   localparam int EW = WORD_WIDTH + 2;

`ifdef PARAM_SWEEP_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   logic signed [EW-1:0]         v_ext;
   logic signed [EW-1:0]         g_ext;
   logic signed [EW-1:0]         w_ext;
   logic signed [EW-1:0]         v_full;
   logic signed [EW-1:0]         w_full;
   logic signed [WORD_WIDTH-1:0] v_new;

   // Momentum step, then weight step using the already-reduced velocity.
   // NOTE: every variable is assigned on every pass through always_comb, so no latch is inferred.
   always_comb begin
      v_ext  = EW'(v_i);
      g_ext  = EW'(g_i);
      w_ext  = EW'(w_i);
      v_full = v_ext - (v_ext >>> MU_SHIFT) - (g_ext >>> LR_SHIFT);
      v_new  = WORD_WIDTH'(reduce_word(64'(v_full), WORD_WIDTH, SAT_EN));
      w_full = w_ext + EW'(v_new);
      w_o    = WORD_WIDTH'(reduce_word(64'(w_full), WORD_WIDTH, SAT_EN));
      v_o    = v_new;
   end

endmodule

// File: rtl/param_sweep_engine.sv
// Sweep engine for one layer's parameter store. ZERO_GRAD clears one
// channel slice of the grad RAM a row per cycle; UPDATE streams a slice of
// w/v/grad through a two-stage pipe and writes new w/v rows back.
// Lane arithmetic saturates when PARAM_SWEEP_SAT_EN is defined, else wraps.
import param_sweep_engine_pkg::*;

module param_sweep_engine #(
   parameter  int LANES      = 4,
   parameter  int WORD_WIDTH = 18,
   parameter  int DEPTH      = 432,
   parameter  int N_CH       = 3,
   parameter  int ADDR_WIDTH = 11,
   parameter  int LR_SHIFT   = 7,
   parameter  int MU_SHIFT   = 3,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int ROW_W      = LANES * WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   input  logic                  cmd_op,
   input  logic [CH_W-1:0]       cmd_ch,
   output logic                  cmd_ready,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [ROW_W-1:0]      rdata_w,
   input  logic [ROW_W-1:0]      rdata_v,
   input  logic [ROW_W-1:0]      rdata_grad,
   output logic                  we_wv,
   output logic                  we_grad,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ROW_W-1:0]      wdata_w,
   output logic [ROW_W-1:0]      wdata_v,
   output logic [ROW_W-1:0]      wdata_grad
);

   localparam int              CNT_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(PIPE_DEPTH - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
   logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
   logic                    s1_vld_q;
   logic [ADDR_WIDTH-1:0]   s1_addr_q;
   logic                    s2_vld_q;
   logic [ROW_W-1:0]        wdata_w_q, wdata_v_q;
   logic [ROW_W-1:0]        lane_w, lane_v;
   logic [ADDR_WIDTH-1:0]   base;
   logic                    ch_ok;

   // Slice base of the requested channel; out-of-range channels sweep nothing.
   assign base  = ADDR_WIDTH'(cmd_ch) * ADDR_WIDTH'(DEPTH);
   assign ch_ok = (int'(cmd_ch) < N_CH);

   // Next-state, row counter and address stepping, plus status outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      raddr_d   = raddr_q;
      waddr_d   = waddr_q;
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      we_grad   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               cnt_d = '0;
               if (!ch_ok) begin
                  state_d = S_DONE;
               end else if (cmd_op == OP_UPDATE) begin
                  state_d = S_RD;
                  raddr_d = base;
               end else begin
                  state_d = S_ZERO;
                  waddr_d = base;
               end
            end
         end
         S_ZERO: begin
            busy    = 1'b1;
            we_grad = 1'b1;
            if (cnt_q == LAST_ROW) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               waddr_d = waddr_q + ADDR_WIDTH'(1);
            end
         end
         S_RD: begin
            busy = 1'b1;
            if (cnt_q == LAST_ROW) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               raddr_d = raddr_q + ADDR_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (cnt_q == LAST_DRAIN) state_d = S_DONE;
            else                     cnt_d   = cnt_q + CNT_W'(1);
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // The update pipe owns the write address; it never overlaps a ZERO pass.
      if (s1_vld_q) waddr_d = s1_addr_q;
   end

   // FSM state register.
   // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Counters, address registers and the two-stage update pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         raddr_q   <= '0;
         waddr_q   <= '0;
         s1_vld_q  <= 1'b0;
         s1_addr_q <= '0;
         s2_vld_q  <= 1'b0;
         wdata_w_q <= '0;
         wdata_v_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         raddr_q   <= raddr_d;
         waddr_q   <= waddr_d;
         s1_vld_q  <= (state_q == S_RD);
         s1_addr_q <= raddr_q;
         s2_vld_q  <= s1_vld_q;
         if (s1_vld_q) begin
            wdata_w_q <= lane_w;
            wdata_v_q <= lane_v;
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      param_sweep_lane #(
         .WORD_WIDTH (WORD_WIDTH),
         .LR_SHIFT   (LR_SHIFT),
         .MU_SHIFT   (MU_SHIFT)
      ) u_lane (
         .w_i (rdata_w   [l*WORD_WIDTH +: WORD_WIDTH]),
         .v_i (rdata_v   [l*WORD_WIDTH +: WORD_WIDTH]),
         .g_i (rdata_grad[l*WORD_WIDTH +: WORD_WIDTH]),
         .w_o (lane_w    [l*WORD_WIDTH +: WORD_WIDTH]),
         .v_o (lane_v    [l*WORD_WIDTH +: WORD_WIDTH])
      );
   end

   assign raddr      = raddr_q;
   assign waddr      = waddr_q;
   assign we_wv      = s2_vld_q;
   assign wdata_w    = wdata_w_q;
   assign wdata_v    = wdata_v_q;
   assign wdata_grad = '0;

endmodule

// File: tb/tb_param_sweep_engine.sv
// Directed bench for param_sweep_engine with behavioural w/v/grad RAMs.
// Expected values are hand-computed; PARAM_SWEEP_SAT_EN selects the
// saturating or wrapping expectations for the overflow test.
module tb_param_sweep_engine;

   localparam int LANES    = 4;
   localparam int WW       = 18;
   localparam int DEPTH    = 432;
   localparam int N_CH     = 3;
   localparam int AW       = 11;
   localparam int ROW_W    = LANES * WW;
   localparam int MEM_ROWS = 1 << AW;
   localparam int LIMIT    = 1000;
   localparam int CH0      = 0;
   localparam int CH1      = DEPTH;
   localparam int CH2      = 2 * DEPTH;
   localparam int SEL_W    = 0;
   localparam int SEL_V    = 1;
   localparam int SEL_G    = 2;

`ifdef PARAM_SWEEP_SAT_EN
   localparam int EXP_WA = 131071;
   localparam int EXP_WB = -131072;
`else
   localparam int EXP_WA = -131065;
   localparam int EXP_WB = 131064;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_op = 1'b0;
   logic [1:0]       cmd_ch = '0;
   logic             cmd_ready, busy, done, we_wv, we_grad;
   logic [AW-1:0]    raddr, waddr;
   logic [ROW_W-1:0] rdata_w, rdata_v, rdata_grad;
   logic [ROW_W-1:0] wdata_w, wdata_v, wdata_grad;

   logic [ROW_W-1:0] mem_w [MEM_ROWS];
   logic [ROW_W-1:0] mem_v [MEM_ROWS];
   logic [ROW_W-1:0] mem_g [MEM_ROWS];
   logic             ld_w_en = 1'b0, ld_v_en = 1'b0, ld_g_en = 1'b0;
   logic [ROW_W-1:0] ld_w = '0, ld_v = '0, ld_g = '0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   param_sweep_engine #(
      .LANES(LANES), .WORD_WIDTH(WW), .DEPTH(DEPTH), .N_CH(N_CH),
      .ADDR_WIDTH(AW), .LR_SHIFT(7), .MU_SHIFT(3)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
      .cmd_ready(cmd_ready), .busy(busy), .done(done), .raddr(raddr),
      .rdata_w(rdata_w), .rdata_v(rdata_v), .rdata_grad(rdata_grad),
      .we_wv(we_wv), .we_grad(we_grad), .waddr(waddr),
      .wdata_w(wdata_w), .wdata_v(wdata_v), .wdata_grad(wdata_grad)
   );

   // Synchronous RAMs: one-cycle read latency, bulk preload when idle.
   always @(posedge clk) begin
      for (int i = 0; i < MEM_ROWS; i++) begin
         if (ld_w_en) mem_w[i] <= ld_w;
         if (ld_v_en) mem_v[i] <= ld_v;
         if (ld_g_en) mem_g[i] <= ld_g;
      end
      if (we_wv) begin
         mem_w[waddr] <= wdata_w;
         mem_v[waddr] <= wdata_v;
      end
      if (we_grad) mem_g[waddr] <= wdata_grad;
      rdata_w    <= mem_w[raddr];
      rdata_v    <= mem_v[raddr];
      rdata_grad <= mem_g[raddr];
   end

   function automatic logic [ROW_W-1:0] rowl(input int l3, input int l2, input int l1, input int l0);
      return {18'(l3), 18'(l2), 18'(l1), 18'(l0)};
   endfunction

   function automatic logic [ROW_W-1:0] row4(input int a);
      return rowl(a, a, a, a);
   endfunction

   function automatic logic [ROW_W-1:0] rd_mem(input int sel, input int a);
      case (sel)
         SEL_W:   return mem_w[a];
         SEL_V:   return mem_v[a];
         default: return mem_g[a];
      endcase
   endfunction

   task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compares a row range against one value; reports the first differing row.
   task automatic check_rows(input string tag, input int sel, input int lo, input int hi,
                             input logic [ROW_W-1:0] exp);
      logic [ROW_W-1:0] obs;
      logic [ROW_W-1:0] cur;
      bit               seen;
      seen = 1'b0;
      obs  = rd_mem(sel, lo);
      for (int i = lo; i <= hi; i++) begin
         cur = rd_mem(sel, i);
         if (!seen && (cur !== exp)) begin
            obs  = cur;
            seen = 1'b1;
         end
      end
      check(tag, obs, exp);
   endtask

   task automatic load(input logic [ROW_W-1:0] w, input logic [ROW_W-1:0] v, input logic [ROW_W-1:0] g);
      @(negedge clk);
      ld_w = w; ld_v = v; ld_g = g;
      ld_w_en = 1'b1; ld_v_en = 1'b1; ld_g_en = 1'b1;
      @(negedge clk);
      ld_w_en = 1'b0; ld_v_en = 1'b0; ld_g_en = 1'b0;
   endtask

   // Called at a negedge while idle; the command is accepted at the next posedge.
   task automatic start(input logic op, input logic [1:0] ch, input string tag);
      check_int({tag, "_ready"}, int'(cmd_ready), 1);
      cmd_op    = op;
      cmd_ch    = ch;
      cmd_valid = 1'b1;
   endtask

   // Counts cycles from the accept cycle to done, and write strobes on the way.
   task automatic wait_done(input bit hold, output int lat, output int n_wv,
                            output int n_grad, output int busy_low);
      lat = -1; n_wv = 0; n_grad = 0; busy_low = 0;
      for (int k = 1; k <= LIMIT; k++) begin
         @(negedge clk);
         if (!hold) cmd_valid = 1'b0;
         if (we_wv)   n_wv++;
         if (we_grad) n_grad++;
         if (done) begin
            lat = k;
            break;
         end
         if (!busy) busy_low++;
      end
   endtask

   task automatic after_done(input string tag);
      @(negedge clk);
      check_int({tag, "_done_pulse"}, int'(done), 0);
      check_int({tag, "_ready_back"}, int'(cmd_ready), 1);
   endtask

   task automatic run(input logic op, input logic [1:0] ch, input string tag,
                      input int exp_lat, input int exp_wv, input int exp_grad);
      int lat, n_wv, n_grad, busy_low;
      start(op, ch, tag);
      wait_done(1'b0, lat, n_wv, n_grad, busy_low);
      check_int({tag, "_latency"}, lat, exp_lat);
      check_int({tag, "_we_wv_count"}, n_wv, exp_wv);
      check_int({tag, "_we_grad_count"}, n_grad, exp_grad);
      check_int({tag, "_busy_gaps"}, busy_low, 0);
      after_done(tag);
   endtask

   initial begin
      int lat, n_wv, n_grad, busy_low;

      // Reset values
      repeat (3) @(negedge clk);
      check_int("rst_ready", int'(cmd_ready), 1);
      check_int("rst_busy", int'(busy), 0);
      check_int("rst_done", int'(done), 0);
      check_int("rst_we_wv", int'(we_wv), 0);
      check_int("rst_we_grad", int'(we_grad), 0);
      check_int("rst_raddr", int'(raddr), 0);
      check_int("rst_waddr", int'(waddr), 0);
      check("rst_wdata_w", wdata_w, '0);
      check("rst_wdata_v", wdata_v, '0);
      check("rst_wdata_grad", wdata_grad, '0);
      rst = 1'b0;

      // 1: ZERO_GRAD on channel 1 only
      load(row4(100), row4(0), row4('h155));
      run(1'b0, 2'd1, "zero_ch1", DEPTH + 1, 0, DEPTH);
      check_rows("zero_ch0_untouched", SEL_G, CH0, CH1 - 1, row4('h155));
      check_rows("zero_ch1_cleared", SEL_G, CH1, CH2 - 1, row4(0));
      check_rows("zero_ch2_untouched", SEL_G, CH2, CH2 + DEPTH - 1, row4('h155));
      check_int("zero_waddr_hold", int'(waddr), CH2 - 1);
      check_int("zero_raddr_hold", int'(raddr), 0);

      // 2: UPDATE ch0, w=100 v=0 g=256 -> v'=-2 w'=98
      load(row4(100), row4(0), row4(256));
      run(1'b1, 2'd0, "upd_ch0", DEPTH + 3, DEPTH, 0);
      check_rows("upd_ch0_w", SEL_W, CH0, CH1 - 1, row4(98));
      check_rows("upd_ch0_v", SEL_V, CH0, CH1 - 1, row4(-2));
      check_rows("upd_ch0_g_kept", SEL_G, CH0, CH1 - 1, row4(256));
      check_rows("upd_ch1_w_untouched", SEL_W, CH1, CH2 - 1, row4(100));
      check_int("upd_raddr_hold", int'(raddr), CH1 - 1);
      check_int("upd_waddr_hold", int'(waddr), CH1 - 1);

      // 3: UPDATE ch2, v=-16 g=0 -> v'=-14 w'=986
      load(row4(1000), row4(-16), row4(0));
      run(1'b1, 2'd2, "upd_ch2", DEPTH + 3, DEPTH, 0);
      check_rows("upd_ch2_v", SEL_V, CH2, CH2 + DEPTH - 1, row4(-14));
      check_rows("upd_ch2_w", SEL_W, CH2, CH2 + DEPTH - 1, row4(986));
      check_rows("upd_ch2_g_kept", SEL_G, CH2, CH2 + DEPTH - 1, row4(0));
      check_rows("upd_ch0_v_untouched", SEL_V, CH0, CH1 - 1, row4(-16));

      // 3b: distinct lanes on ch1, including an arithmetic shift of a negative odd value
      load(row4(1000), rowl(0, 8, 64, -17), rowl(1024, -256, 128, 0));
      run(1'b1, 2'd1, "upd_lanes", DEPTH + 3, DEPTH, 0);
      check_rows("upd_lanes_v", SEL_V, CH1, CH2 - 1, rowl(-8, 9, 55, -14));
      check_rows("upd_lanes_w", SEL_W, CH1, CH2 - 1, rowl(992, 1009, 1055, 986));

      // 4: overflow in both directions
      load(rowl(-131072, 131071, -131072, 131071), row4(0), rowl(1024, -1024, 1024, -1024));
      run(1'b1, 2'd1, "upd_ovf", DEPTH + 3, DEPTH, 0);
      check_rows("upd_ovf_v", SEL_V, CH1, CH2 - 1, rowl(-8, 8, -8, 8));
      check_rows("upd_ovf_w", SEL_W, CH1, CH2 - 1, rowl(EXP_WB, EXP_WA, EXP_WB, EXP_WA));

      // 5: cmd_valid held through an UPDATE; second accept only once ready again
      load(row4(100), row4(0), row4(256));
      start(1'b1, 2'd0, "hold1");
      wait_done(1'b1, lat, n_wv, n_grad, busy_low);
      check_int("hold1_latency", lat, DEPTH + 3);
      check_int("hold1_busy_gaps", busy_low, 0);
      check_int("hold1_ready_at_done", int'(cmd_ready), 0);
      @(negedge clk);
      check_int("hold1_single_done", int'(done), 0);
      check_int("hold2_ready_rises", int'(cmd_ready), 1);
      wait_done(1'b0, lat, n_wv, n_grad, busy_low);
      check_int("hold2_latency", lat, DEPTH + 3);
      check_int("hold2_we_wv_count", n_wv, DEPTH);
      after_done("hold2");
      check_rows("hold2_w", SEL_W, CH0, CH1 - 1, row4(95));
      check_rows("hold2_v", SEL_V, CH0, CH1 - 1, row4(-3));

      // 6: reset during an UPDATE of ch2; rows 0..198 are already written
      load(row4(500), row4(0), row4(256));
      start(1'b1, 2'd2, "abort");
      for (int k = 1; k <= 201; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_int("abort_we_wv", int'(we_wv), 0);
      check_int("abort_busy", int'(busy), 0);
      check_int("abort_ready", int'(cmd_ready), 1);
      check_int("abort_raddr", int'(raddr), 0);
      check_rows("abort_w_written", SEL_W, CH2, CH2 + 198, row4(498));
      check_rows("abort_w_left", SEL_W, CH2 + 199, CH2 + DEPTH - 1, row4(500));
      check_rows("abort_v_left", SEL_V, CH2 + 199, CH2 + DEPTH - 1, row4(0));
      run(1'b0, 2'd2, "abort_zero", DEPTH + 1, 0, DEPTH);
      check_rows("abort_zero_g", SEL_G, CH2, CH2 + DEPTH - 1, row4(0));
      check_rows("abort_zero_ch1_g", SEL_G, CH1, CH2 - 1, row4(256));

      // Out-of-range channel: no writes, done one cycle after accept
      run(1'b1, 2'd3, "bad_ch_upd", 1, 0, 0);
      run(1'b0, 2'd3, "bad_ch_zero", 1, 0, 0);
      check_rows("bad_ch_g_kept", SEL_G, CH0, CH1 - 1, row4(256));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
